// File: rtl/simon_pkg.sv
// simon_pkg: state encoding, colour types and default timing shared by the player and memory loader
package simon_pkg;
  typedef enum logic [3:0] {IDLE, FETCH, SHOW, GAP, WAIT_IN, CHECK, RELEASE, WIN, LOSE} state_e;
  typedef logic [1:0] colour_t;
  typedef logic [3:0] onehot_t;
  localparam int DEF_STEPS = 16;
  localparam int DEF_SHOW_CYCLES = 8;
  localparam int DEF_GAP_CYCLES = 4;
  localparam int DEF_TIMEOUT_CYCLES = 64;
endpackage

// File: rtl/colour_dec.sv
// colour_dec: 2-bit colour code to one-hot lamp/button pattern
module colour_dec import simon_pkg::*; (
  input  colour_t code,
  output onehot_t onehot
);
  assign onehot = onehot_t'(1) << code;
endmodule

// File: rtl/seq_player.sv
// seq_player: plays back a growing colour sequence from memory, then checks the player's presses
module seq_player import simon_pkg::*; #(
  parameter int STEPS = DEF_STEPS,
  parameter int SHOW_CYCLES = DEF_SHOW_CYCLES,
  parameter int GAP_CYCLES = DEF_GAP_CYCLES,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  output logic [3:0] mem_rd_addr,
  input  logic [1:0] mem_rd_data,
  input  logic [3:0] colour_in,
  output logic [3:0] led_out,
  output logic [4:0] round,
  output logic       busy,
  output logic       win,
  output logic       lose
);
  localparam logic [15:0] SHOW_LAST = 16'(SHOW_CYCLES - 1);
  localparam logic [15:0] GAP_LAST = 16'(GAP_CYCLES - 1);
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);
  state_e state, state_n;
  logic [3:0] step, step_n, addr_n;
  logic [4:0] round_n;
  logic [15:0] cnt, cnt_n;
  logic play, play_n, fwait, fwait_n, armed, armed_n, last;
  colour_t code, code_n;
  onehot_t press, press_n, dec;
  colour_dec u_dec (.code(code), .onehot(dec));
  assign last = {1'b0, step} + 5'd1 >= round;
  assign busy = state != IDLE;
  assign win = state == WIN;
  assign lose = state == LOSE;
  assign led_out = state == SHOW ? dec : (state == WAIT_IN || state == RELEASE) ? colour_in : 4'b0000;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      step <= '0;
      round <= '0;
      cnt <= '0;
      play <= 1'b0;
      fwait <= 1'b0;
      armed <= 1'b0;
      code <= '0;
      press <= '0;
      mem_rd_addr <= '0;
    end else begin
      state <= state_n;
      step <= step_n;
      round <= round_n;
      cnt <= cnt_n;
      play <= play_n;
      fwait <= fwait_n;
      armed <= armed_n;
      code <= code_n;
      press <= press_n;
      mem_rd_addr <= addr_n;
    end
  end
  // fetch spends one clock presenting the address and one receiving the registered read data
  always_comb begin
    state_n = state;
    step_n = step;
    round_n = round;
    cnt_n = '0;
    play_n = play;
    fwait_n = 1'b0;
    armed_n = 1'b0;
    code_n = code;
    press_n = press;
    addr_n = mem_rd_addr;
    case (state)
      IDLE: if (start) begin
        state_n = FETCH;
        round_n = 5'd1;
        step_n = '0;
        play_n = 1'b1;
        addr_n = '0;
      end
      FETCH: begin
        fwait_n = !fwait;
        if (fwait) begin
          code_n = mem_rd_data;
          state_n = play ? SHOW : CHECK;
        end
      end
      SHOW: if (cnt == SHOW_LAST) state_n = GAP; else cnt_n = cnt + 16'd1;
      GAP: if (cnt != GAP_LAST) cnt_n = cnt + 16'd1;
      else if (!last) begin
        step_n = step + 4'd1;
        addr_n = step + 4'd1;
        state_n = FETCH;
      end else begin
        step_n = '0;
        play_n = 1'b0;
        state_n = WAIT_IN;
      end
      // armed only after colour_in has been seen at zero inside WAIT_IN, so held buttons never count
      WAIT_IN: begin
        armed_n = colour_in == 4'b0000;
        if (armed && colour_in != 4'b0000) begin
          press_n = colour_in;
          addr_n = step;
          state_n = FETCH;
        end else if (cnt == TMO_LAST) state_n = LOSE;
        else cnt_n = cnt + 16'd1;
      end
      CHECK: state_n = press == dec ? RELEASE : LOSE;
      RELEASE: if (colour_in == 4'b0000) begin
        if (!last) begin
          step_n = step + 4'd1;
          state_n = WAIT_IN;
        end else if (round == 5'(STEPS)) state_n = WIN;
        else begin
          round_n = round + 5'd1;
          step_n = '0;
          addr_n = '0;
          play_n = 1'b1;
          state_n = FETCH;
        end
      end
      WIN, LOSE: begin
        state_n = IDLE;
        round_n = '0;
        step_n = '0;
      end
      default: state_n = IDLE;
    endcase
  end
endmodule

// File: tb/tb_seq_player.sv
// tb_seq_player: randomized game stimulus against a sequence-level model of the colour game
module tb_seq_player;
  localparam int SHOW = 8, GAP = 4, TMO = 64;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n, start, sel;
  logic [3:0] colour_in;
  logic [1:0] mem [16];
  logic [3:0] addr_a, addr_b, led_a, led_b, led, addr;
  logic [1:0] rd_a, rd_b;
  logic [4:0] round_a, round_b, round;
  logic busy_a, busy_b, win_a, win_b, lose_a, lose_b, busy, win, lose;
  int tests = 0, fails = 0;
  seq_player u_dut (.clk(clk), .rst_n(rst_n), .start(start), .mem_rd_addr(addr_a), .mem_rd_data(rd_a),
    .colour_in(colour_in), .led_out(led_a), .round(round_a), .busy(busy_a), .win(win_a), .lose(lose_a));
  seq_player #(.STEPS(2)) u_two (.clk(clk), .rst_n(rst_n), .start(start), .mem_rd_addr(addr_b), .mem_rd_data(rd_b),
    .colour_in(colour_in), .led_out(led_b), .round(round_b), .busy(busy_b), .win(win_b), .lose(lose_b));
  always @(posedge clk) begin
    rd_a <= mem[addr_a];
    rd_b <= mem[addr_b];
  end
  assign led = sel ? led_b : led_a;
  assign addr = sel ? addr_b : addr_a;
  assign round = sel ? round_b : round_a;
  assign busy = sel ? busy_b : busy_a;
  assign win = sel ? win_b : win_a;
  assign lose = sel ? lose_b : lose_a;
  function automatic logic [3:0] onehot(input logic [1:0] c);
    return 4'b0001 << c;
  endfunction
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic do_reset;
    rst_n = 1'b0;
    start = 1'b0;
    colour_in = 4'b0;
    cyc(2);
    rst_n = 1'b1;
    cyc(1);
  endtask
  task automatic fill_mem;
    for (int i = 0; i < 16; i++) mem[i] = 2'($urandom_range(0, 3));
  endtask
  task automatic begin_game;
    start = 1'b1;
    cyc(1);
    start = 1'b0;
  endtask
  task automatic press(input logic [3:0] c);
    cyc(6);
    colour_in = c;
    cyc(2);
    colour_in = 4'b0;
  endtask
  // round r shows mem[0..r-1], each lit SHOW clocks, separated by at least GAP dark clocks
  task automatic watch_playback(input int r);
    int t, len;
    logic [3:0] exp;
    for (int i = 0; i < r; i++) begin
      exp = onehot(mem[i]);
      t = 0;
      while (led === 4'b0 && t < 200) begin cyc(1); t++; end
      tests++;
      if (led !== exp) begin fails++; $display("FAIL play_colour r%0d s%0d: got %b want %b", r, i, led, exp); end
      if (i == 0) begin
        tests++;
        if (round !== 5'(r) || busy !== 1'b1) begin fails++; $display("FAIL play_round: got round %0d busy %b want %0d 1", round, busy, r); end
      end else begin
        tests++;
        if (t < GAP || t > GAP + 2) begin fails++; $display("FAIL play_gap r%0d s%0d: got %0d dark want %0d..%0d", r, i, t, GAP, GAP + 2); end
      end
      len = 0;
      while (led === exp && len < 100) begin cyc(1); len++; end
      tests++;
      if (len != SHOW) begin fails++; $display("FAIL play_len r%0d s%0d: got %0d want %0d", r, i, len, SHOW); end
    end
  endtask
  task automatic play_round(input int r);
    watch_playback(r);
    for (int i = 0; i < r; i++) press(onehot(mem[i]));
  endtask
  task automatic expect_end(input bit want_win, input int bound, input string tag);
    int t = 0;
    bit other = 1'b0;
    while (!(want_win ? win : lose) && t < bound) begin
      if (want_win ? lose : win) other = 1'b1;
      cyc(1);
      t++;
    end
    tests++;
    if (!(want_win ? win : lose)) begin fails++; $display("FAIL %s pulse: got none within %0d clocks want one", tag, bound); end
    tests++;
    if (other) begin fails++; $display("FAIL %s wrong_pulse: got opposite outcome want none", tag); end
    cyc(1);
    tests++;
    if (win !== 1'b0 || lose !== 1'b0 || round !== 5'd0 || busy !== 1'b0)
      begin fails++; $display("FAIL %s after: got win %b lose %b round %0d busy %b want 0 0 0 0", tag, win, lose, round, busy); end
  endtask
  task automatic test_reset;
    sel = 1'b0;
    do_reset;
    tests++;
    if (led !== 4'b0 || round !== 5'd0 || busy !== 1'b0 || win !== 1'b0 || lose !== 1'b0 || addr !== 4'd0)
      begin fails++; $display("FAIL reset: got led %b round %0d busy %b win %b lose %b addr %0d want all 0", led, round, busy, win, lose, addr); end
    begin_game;
    tests++;
    if (round !== 5'd1 || busy !== 1'b1) begin fails++; $display("FAIL start: got round %0d busy %b want 1 1", round, busy); end
  endtask
  task automatic test_basic;
    sel = 1'b0;
    do_reset;
    mem[0] = 2'b10;
    mem[1] = 2'b00;
    begin_game;
    play_round(1);
    watch_playback(2);
  endtask
  task automatic test_wrong_colour;
    sel = 1'b0;
    do_reset;
    mem[0] = 2'b01;
    begin_game;
    watch_playback(1);
    press(4'b1000);
    expect_end(1'b0, 30, "wrong_colour");
  endtask
  task automatic test_multihot;
    sel = 1'b0;
    do_reset;
    mem[0] = 2'b00;
    begin_game;
    watch_playback(1);
    press(4'b0011);
    expect_end(1'b0, 30, "multihot");
  endtask
  task automatic test_timeout;
    int t = 0;
    sel = 1'b0;
    do_reset;
    fill_mem;
    begin_game;
    watch_playback(1);
    while (!lose && t < 200) begin cyc(1); t++; end
    tests++;
    if (t < GAP + TMO - 1 || t > GAP + TMO + 1) begin fails++; $display("FAIL timeout: got lose after %0d clocks want %0d..%0d", t, GAP + TMO - 1, GAP + TMO + 1); end
    expect_end(1'b0, 5, "timeout");
  endtask
  task automatic test_held;
    logic [3:0] bad;
    sel = 1'b0;
    do_reset;
    fill_mem;
    bad = onehot(mem[0]) ^ 4'b1111;
    begin_game;
    colour_in = bad;
    watch_playback(1);
    cyc(GAP + 8);
    tests++;
    if (led !== bad || round !== 5'd1 || busy !== 1'b1 || lose !== 1'b0)
      begin fails++; $display("FAIL held: got led %b round %0d busy %b lose %b want %b 1 1 0", led, round, busy, lose, bad); end
    colour_in = 4'b0;
    press(onehot(mem[0]));
    watch_playback(2);
  endtask
  task automatic test_win;
    int n = 0;
    sel = 1'b1;
    do_reset;
    fill_mem;
    begin_game;
    play_round(1);
    play_round(2);
    expect_end(1'b1, 30, "win");
    for (int i = 0; i < 20; i++) begin if (win) n++; cyc(1); end
    tests++;
    if (n != 0) begin fails++; $display("FAIL win_once: got %0d extra win clocks want 0", n); end
    sel = 1'b0;
  endtask
  task automatic test_mid_reset;
    int t = 0;
    sel = 1'b0;
    do_reset;
    fill_mem;
    begin_game;
    play_round(1);
    play_round(2);
    while (led === 4'b0 && t < 200) begin cyc(1); t++; end
    tests++;
    if (round !== 5'd3 || led !== onehot(mem[0])) begin fails++; $display("FAIL mid_show: got round %0d led %b want 3 %b", round, led, onehot(mem[0])); end
    #2 rst_n = 1'b0;
    #1;
    tests++;
    if (led !== 4'b0 || round !== 5'd0 || busy !== 1'b0 || addr !== 4'd0)
      begin fails++; $display("FAIL async_reset: got led %b round %0d busy %b addr %0d want 0 0 0 0", led, round, busy, addr); end
    start = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    tests++;
    if (round !== 5'd0 || busy !== 1'b0) begin fails++; $display("FAIL reset_release: got round %0d busy %b want 0 0", round, busy); end
    @(negedge clk);
    start = 1'b0;
    tests++;
    if (round !== 5'd1 || busy !== 1'b1) begin fails++; $display("FAIL restart: got round %0d busy %b want 1 1", round, busy); end
  endtask
  task automatic test_random_games;
    int k, j;
    logic [3:0] bad;
    sel = 1'b0;
    for (int g = 0; g < 4; g++) begin
      k = $urandom_range(1, 4);
      j = $urandom_range(0, k - 1);
      fill_mem;
      do_reset;
      begin_game;
      for (int r = 1; r < k; r++) play_round(r);
      watch_playback(k);
      for (int i = 0; i < j; i++) press(onehot(mem[i]));
      bad = onehot(mem[j]);
      while (bad == onehot(mem[j])) bad = 4'($urandom_range(1, 15));
      press(bad);
      expect_end(1'b0, 30, "rand_lose");
    end
  endtask
  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    colour_in = 4'b0;
    sel = 1'b0;
    for (int i = 0; i < 16; i++) mem[i] = 2'b00;
    test_reset;
    test_basic;
    test_wrong_colour;
    test_multihot;
    test_timeout;
    test_held;
    test_win;
    test_mid_reset;
    test_random_games;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
